hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer_pkg.sv | 53 +++++
 rtl/hazard_sequencer_if.sv | 38 +++
 rtl/hazard_sat_counter.sv | 23 ++
 rtl/hazard_sequencer.sv | 96 +++++++++
 tb/tb_hazard_sequencer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline definitions for the hazard sequencer: state encoding, result-select codes
// and the stall/flush control bundle.
package hazard_sequencer_pkg;

   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned RESULT_SRC_W = 3;

   localparam logic [RESULT_SRC_W-1:0] RESULT_SRC_LOAD = 3'b001;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StErr     = 2'd2
   } hs_state_e;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic flush_d;
      logic flush_e;
   } hs_ctrl_t;

   localparam hs_ctrl_t CTRL_NONE      = '0;
   localparam hs_ctrl_t CTRL_STALL_ALL = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                           stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0};

   function automatic logic load_use(input logic [REG_ADDR_W-1:0]   rs1_addr,
                                     input logic [REG_ADDR_W-1:0]   rs2_addr,
                                     input logic [REG_ADDR_W-1:0]   rd_addr,
                                     input logic [RESULT_SRC_W-1:0] result_src);
      return (result_src == RESULT_SRC_LOAD) && (rd_addr != '0) &&
             ((rd_addr == rs1_addr) || (rd_addr == rs2_addr));
   endfunction

   // Control with no memory stall: a resolved branch squashes decode/execute and hides any
   // load-use hazard on the wrong-path instruction; otherwise a hazard inserts one bubble.
   function automatic hs_ctrl_t run_ctrl(input logic pc_src, input logic lu);
      hs_ctrl_t c;
      c = CTRL_NONE;
      if (pc_src) begin
         c.flush_d = 1'b1;
         c.flush_e = 1'b1;
      end else if (lu) begin
         c.stall_f = 1'b1;
         c.stall_d = 1'b1;
         c.flush_e = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-side bundle of hazard inputs and stall/flush/status outputs.
interface hazard_sequencer_if
   import hazard_sequencer_pkg::*;
#(
   parameter int unsigned CNT_W = 32
);
   logic [REG_ADDR_W-1:0]   i_rs1_addrD;
   logic [REG_ADDR_W-1:0]   i_rs2_addrD;
   logic [REG_ADDR_W-1:0]   i_rd_addrE;
   logic [RESULT_SRC_W-1:0] i_result_srcE;
   logic                    i_pc_srcE;
   logic                    i_mem_req;
   logic                    i_mem_ready;

   logic                    o_stallF;
   logic                    o_stallD;
   logic                    o_stallE;
   logic                    o_stallM;
   logic                    o_flushD;
   logic                    o_flushE;
   logic                    o_err;
   logic [CNT_W-1:0]        o_stall_cycles;

   modport master (
      output i_rs1_addrD, i_rs2_addrD, i_rd_addrE, i_result_srcE, i_pc_srcE,
             i_mem_req, i_mem_ready,
      input  o_stallF, o_stallD, o_stallE, o_stallM, o_flushD, o_flushE, o_err,
             o_stall_cycles
   );

   modport slave (
      input  i_rs1_addrD, i_rs2_addrD, i_rd_addrE, i_result_srcE, i_pc_srcE,
             i_mem_req, i_mem_ready,
      output o_stallF, o_stallD, o_stallE, o_stallM, o_flushD, o_flushE, o_err,
             o_stall_cycles
   );

endinterface

// File: rtl/hazard_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count_q;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_count_q <= '0;
      end else if (i_en && (r_count_q != '1)) begin
         r_count_q <= r_count_q + WIDTH'(1);
      end
   end

   assign o_count = r_count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes, memory-wait stalls with a
// timeout into a sticky error state, and a saturating stall-cycle counter.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 32
) (
   input  logic               i_clk,
   input  logic               i_arst,
   hazard_sequencer_if.slave  bus
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   hs_state_e       r_state_q;
   hs_state_e       w_state_d;
   logic [TO_W-1:0] r_to_q;
   logic [TO_W-1:0] w_to_d;
   hs_ctrl_t        w_ctrl;
   hs_ctrl_t        w_ctrl_out;
   logic            w_lu;
   logic            w_ms;

   assign w_lu = load_use(bus.i_rs1_addrD, bus.i_rs2_addrD, bus.i_rd_addrE, bus.i_result_srcE);
   assign w_ms = bus.i_mem_req & ~bus.i_mem_ready;

   always_comb begin
      w_state_d = r_state_q;
      w_to_d    = r_to_q;
      w_ctrl    = CTRL_NONE;
      unique case (r_state_q)
         StRun: begin
            if (w_ms) begin
               w_ctrl    = CTRL_STALL_ALL;
               w_state_d = StMemWait;
               w_to_d    = '0;
            end else begin
               w_ctrl = run_ctrl(bus.i_pc_srcE, w_lu);
            end
         end
         StMemWait: begin
            if (!bus.i_mem_ready) begin
               w_ctrl = CTRL_STALL_ALL;
               if (r_to_q == TO_LAST) begin
                  w_state_d = StErr;
               end else begin
                  w_to_d = r_to_q + TO_W'(1);
               end
            end else begin
               // Completion cycle: the pipeline moves again, so hazards apply as in RUN.
               w_ctrl    = run_ctrl(bus.i_pc_srcE, w_lu);
               w_state_d = StRun;
            end
         end
         StErr: begin
            w_ctrl = CTRL_STALL_ALL;
         end
         default: begin
            w_state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_state_q <= StRun;
         r_to_q    <= '0;
      end else begin
         r_state_q <= w_state_d;
         r_to_q    <= w_to_d;
      end
   end

   // Outputs are quiet for the whole reset assertion, not only after the first edge.
   assign w_ctrl_out = i_arst ? CTRL_NONE : w_ctrl;

   assign bus.o_stallF = w_ctrl_out.stall_f;
   assign bus.o_stallD = w_ctrl_out.stall_d;
   assign bus.o_stallE = w_ctrl_out.stall_e;
   assign bus.o_stallM = w_ctrl_out.stall_m;
   assign bus.o_flushD = w_ctrl_out.flush_d;
   assign bus.o_flushE = w_ctrl_out.flush_e;
   assign bus.o_err    = (r_state_q == StErr);

   hazard_sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .i_clk   (i_clk),
      .i_arst  (i_arst),
      .i_en    (w_ctrl_out.stall_f),
      .o_count (bus.o_stall_cycles)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: expected stall/flush vectors are queued as each step is
// driven and checked at the following falling edge; registered status checked after edges.
module tb_hazard_sequencer;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned TO    = 4;

   // {stallF, stallD, stallE, stallM, flushD, flushE}
   localparam logic [5:0] OUT_NONE = 6'b000000;
   localparam logic [5:0] OUT_LU   = 6'b110001;
   localparam logic [5:0] OUT_FL   = 6'b000011;
   localparam logic [5:0] OUT_ALL  = 6'b111100;
   localparam logic [2:0] LD       = 3'b001;
   localparam logic [2:0] ALU      = 3'b000;

   typedef struct {
      string      tag;
      logic [5:0] outs;
   } exp_t;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [CNT_W-1:0] model_cnt = '0;
   exp_t sb[$];

   hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

   hazard_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CNT_W)
   ) dut (
      .i_clk  (clk),
      .i_arst (arst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [5:0] outs_now();
      return {bus.o_stallF, bus.o_stallD, bus.o_stallE, bus.o_stallM, bus.o_flushD, bus.o_flushE};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [2:0] src, input logic pcs, input logic mreq,
                         input logic mrdy);
      bus.i_rs1_addrD   = rs1;
      bus.i_rs2_addrD   = rs2;
      bus.i_rd_addrE    = rd;
      bus.i_result_srcE = src;
      bus.i_pc_srcE     = pcs;
      bus.i_mem_req     = mreq;
      bus.i_mem_ready   = mrdy;
   endtask

   // One clock of stimulus; called just after a rising edge, returns just after the next one.
   task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [2:0] src, input logic pcs,
                       input logic mreq, input logic mrdy, input logic [5:0] exp);
      exp_t e;
      set_in(rs1, rs2, rd, src, pcs, mreq, mrdy);
      sb.push_back('{tag: tag, outs: exp});
      @(negedge clk);
      e = sb.pop_front();
      chk(e.tag, {26'd0, outs_now()}, {26'd0, e.outs});
      @(posedge clk);
      #1;
      if (exp[5] && (model_cnt != '1)) model_cnt = model_cnt + 1'b1;
   endtask

   task automatic chk_regs(input string tag, input logic exp_err);
      chk({tag, "_cnt"}, {28'd0, bus.o_stall_cycles}, {28'd0, model_cnt});
      chk({tag, "_err"}, {31'd0, bus.o_err}, {31'd0, exp_err});
   endtask

   // Asserts reset with every hazard input active, checks quiet outputs, then releases.
   task automatic do_reset(input string tag);
      arst = 1'b1;
      set_in(5'd5, 5'd5, 5'd5, LD, 1'b1, 1'b1, 1'b0);
      #1;
      model_cnt = '0;
      chk({tag, "_outs"}, {26'd0, outs_now()}, {26'd0, OUT_NONE});
      chk_regs(tag, 1'b0);
      @(posedge clk);
      #1;
      arst = 1'b0;
   endtask

   initial begin
      do_reset("reset0");

      // Load-use and branch behaviour in RUN
      step("lu_rs1",      5'd5, 5'd0, 5'd5, LD,  1'b0, 1'b0, 1'b0, OUT_LU);
      step("idle",        5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b0, 1'b0, OUT_NONE);
      chk_regs("after_lu", 1'b0);
      step("lu_rs2",      5'd3, 5'd7, 5'd7, LD,  1'b0, 1'b0, 1'b0, OUT_LU);
      step("alu_match",   5'd7, 5'd0, 5'd7, ALU, 1'b0, 1'b0, 1'b0, OUT_NONE);
      step("lu_rd0",      5'd0, 5'd0, 5'd0, LD,  1'b0, 1'b0, 1'b0, OUT_NONE);
      step("lu_and_br",   5'd5, 5'd0, 5'd5, LD,  1'b1, 1'b0, 1'b0, OUT_FL);
      step("br_only",     5'd1, 5'd2, 5'd3, ALU, 1'b1, 1'b0, 1'b0, OUT_FL);
      step("req_ready",   5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b1, OUT_NONE);
      chk_regs("run_done", 1'b0);

      // Memory wait: 3 stalled cycles, then ready (with a branch) releases back to RUN
      do_reset("reset1");
      step("ms_run",      5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      step("mw_ign",      5'd5, 5'd0, 5'd5, LD,  1'b1, 1'b1, 1'b0, OUT_ALL);
      step("mw2",         5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      step("mw_ready_br", 5'd1, 5'd2, 5'd3, ALU, 1'b1, 1'b1, 1'b1, OUT_FL);
      chk_regs("mw_done", 1'b0);
      step("run_after_mw", 5'd4, 5'd9, 5'd9, LD, 1'b0, 1'b0, 1'b0, OUT_LU);
      chk_regs("run_after_mw", 1'b0);

      // Timeout into ERR after 4 MEM_WAIT cycles
      do_reset("reset2");
      step("to_run",      5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      for (int i = 0; i < 3; i++) begin
         step("to_wait",  5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      end
      chk_regs("to_pre", 1'b0);
      step("to_last",     5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      chk_regs("to_err", 1'b1);
      step("err_hold",    5'd1, 5'd2, 5'd3, ALU, 1'b1, 1'b0, 1'b1, OUT_ALL);
      chk_regs("err_hold", 1'b1);
      do_reset("reset_err");
      step("post_err_run", 5'd6, 5'd0, 5'd6, LD, 1'b0, 1'b0, 1'b0, OUT_LU);
      chk_regs("post_err_run", 1'b0);

      // Ready on the final timeout cycle wins over the error transition
      do_reset("reset3");
      step("race_run",    5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      for (int i = 0; i < 3; i++) begin
         step("race_wait", 5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      end
      step("race_ready",  5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b1, OUT_NONE);
      chk_regs("race", 1'b0);
      step("race_run2",   5'd8, 5'd8, 5'd8, LD,  1'b0, 1'b0, 1'b0, OUT_LU);

      // Reset mid-MEM_WAIT, then saturate the 4-bit stall counter
      do_reset("reset4");
      step("mid_run",     5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      step("mid_wait",    5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      do_reset("reset_mw");
      step("post_mw_run", 5'd1, 5'd2, 5'd3, ALU, 1'b1, 1'b0, 1'b0, OUT_FL);
      do_reset("reset5");
      for (int i = 0; i < 15; i++) begin
         step("sat_a",    5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      end
      chk({"sat15"}, {28'd0, bus.o_stall_cycles}, 32'd15);
      for (int i = 0; i < 5; i++) begin
         step("sat_b",    5'd1, 5'd2, 5'd3, ALU, 1'b0, 1'b1, 1'b0, OUT_ALL);
      end
      chk({"sat20"}, {28'd0, bus.o_stall_cycles}, 32'd15);
      chk_regs("sat_end", 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
